// File: rtl/tri_raster_sched.sv
// Frame scheduler for the triangle rasterizer: walks the vertex RAM, culls trivially
// invisible triangles and hands the survivors to the rasterizer one at a time.
module tri_raster_sched #(
    parameter int TRIANGLES   = 72,
    parameter int ADDR_W      = 7,
    parameter int RAM_LATENCY = 2,
    parameter int WIDTH       = 1024,
    parameter int HEIGHT      = 720,
    parameter int TIMEOUT     = 65536
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_start_in,
    input  logic [ADDR_W:0]   tri_count_in,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [59:0]       tri_data_in,
    output logic              rast_valid_out,
    output logic [19:0]       rast_vertex_a_out,
    output logic [19:0]       rast_vertex_b_out,
    output logic [19:0]       rast_vertex_c_out,
    input  logic              rast_last_in,
    output logic [ADDR_W:0]   skipped_count_out,
    output logic              timeout_out
);

    localparam int WW = $clog2(RAM_LATENCY + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [ADDR_W:0] TRI_MAX  = (ADDR_W + 1)'(TRIANGLES);
    localparam logic [WW-1:0]   LAT_LAST = WW'(RAM_LATENCY - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [10:0]     X_LIM    = 11'(WIDTH);
    localparam logic [10:0]     Y_LIM    = 11'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_CHECK,
        S_ISSUE,
        S_RAST,
        S_NEXT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_busy;
    logic              r_frame_done;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W-1:0] r_idx;
    logic [WW-1:0]     r_wait;
    logic [TW-1:0]     r_timer;
    logic [59:0]       r_tri;
    logic [19:0]       r_va;
    logic [19:0]       r_vb;
    logic [19:0]       r_vc;
    logic [ADDR_W:0]   r_skipped;
    logic              r_timeout;

    logic              w_accept;
    logic [ADDR_W:0]   w_n_start;
    logic              w_last_idx;
    logic              w_wait_done;
    logic              w_tmo_hit;
    logic [9:0]        w_ax, w_ay, w_bx, w_by, w_cx, w_cy;
    logic              w_x_off, w_y_off, w_degen, w_cull;

    // A start is refused while the done pulse is still on the wire, so busy never drops mid-pulse.
    assign w_accept    = (r_state == S_IDLE) && frame_start_in && !r_busy;
    assign w_n_start   = (tri_count_in > TRI_MAX) ? TRI_MAX : tri_count_in;
    assign w_last_idx  = ({1'b0, r_idx} == (r_n - 1'b1));
    assign w_wait_done = (r_wait == LAT_LAST);
    assign w_tmo_hit   = (r_timer == TMO_LAST);

    assign w_ax = r_tri[59:50];
    assign w_ay = r_tri[49:40];
    assign w_bx = r_tri[39:30];
    assign w_by = r_tri[29:20];
    assign w_cx = r_tri[19:10];
    assign w_cy = r_tri[9:0];

    assign w_x_off = ({1'b0, w_ax} >= X_LIM) && ({1'b0, w_bx} >= X_LIM) && ({1'b0, w_cx} >= X_LIM);
    assign w_y_off = ({1'b0, w_ay} >= Y_LIM) && ({1'b0, w_by} >= Y_LIM) && ({1'b0, w_cy} >= Y_LIM);
    assign w_degen = (r_tri[59:40] == r_tri[39:20]) && (r_tri[39:20] == r_tri[19:0]);
    assign w_cull  = w_x_off || w_y_off || w_degen;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        rast_valid_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_n_start == '0) ? S_DONE : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (w_wait_done) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = w_cull ? S_NEXT : S_ISSUE;
            end
            S_ISSUE: begin
                rast_valid_out = 1'b1;
                w_next         = S_RAST;
            end
            S_RAST: begin
                if (rast_last_in || w_tmo_hit) begin
                    w_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_next = w_last_idx ? S_DONE : S_RD_WAIT;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Vertex outputs are loaded on entry to ISSUE so they are already stable when the valid pulse is seen.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_n          <= '0;
            r_idx        <= '0;
            r_wait       <= '0;
            r_timer      <= '0;
            r_tri        <= '0;
            r_va         <= '0;
            r_vb         <= '0;
            r_vc         <= '0;
            r_skipped    <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_frame_done <= (r_state == S_DONE);
            if (r_frame_done) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_busy    <= 1'b1;
                        r_n       <= w_n_start;
                        r_skipped <= '0;
                        r_timeout <= 1'b0;
                        r_idx     <= '0;
                        r_wait    <= '0;
                    end
                end
                S_RD_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (w_wait_done) begin
                        r_tri <= tri_data_in;
                    end
                end
                S_CHECK: begin
                    if (w_cull) begin
                        r_skipped <= r_skipped + 1'b1;
                    end else begin
                        r_va <= r_tri[59:40];
                        r_vb <= r_tri[39:20];
                        r_vc <= r_tri[19:0];
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_RAST: begin
                    r_timer <= r_timer + 1'b1;
                    if (!rast_last_in && w_tmo_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!w_last_idx) begin
                        r_idx  <= r_idx + 1'b1;
                        r_wait <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_out          = r_busy;
    assign frame_done_out    = r_frame_done;
    assign rd_addr_out       = r_idx;
    assign rast_vertex_a_out = r_va;
    assign rast_vertex_b_out = r_vb;
    assign rast_vertex_c_out = r_vc;
    assign skipped_count_out = r_skipped;
    assign timeout_out       = r_timeout;

endmodule
